// File: rtl/mem_resp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_resp_pkg                                                         |
// | Shared types and default sizes for the mem_responder block.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mem_resp_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 5;
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    // The counter runs from WAIT_STATES-1 down to 0, so zero wait states needs no load.
    function automatic logic [WAIT_CNT_W-1:0] wait_load(input int ws);
        return (ws > 0) ? WAIT_CNT_W'(ws - 1) : '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_array                                                            |
// | 2**ADDR_W x DATA_W storage, async clear, one write and one read port.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_array #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_responder                                                        |
// | Handshaked read/write target over a 2**ADDR_W x DATA_W memory with   |
// | programmable wait states. Define MEM_RESP_ERR_EN to write-protect    |
// | addresses at or above RO_BASE and report such writes via resp_err.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int WAIT_STATES = 2,
    parameter int RO_BASE     = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

`ifdef MEM_RESP_ERR_EN
    localparam logic c_err_en = 1'b1;
`else
    localparam logic c_err_en = 1'b0;
`endif

    localparam logic [WAIT_CNT_W-1:0] c_wait_load = wait_load(WAIT_STATES);

    state_e                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic                    req_ready_q, req_ready_d;
    logic                    resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]       resp_rdata_q, resp_rdata_d;
    logic                    resp_err_q, resp_err_d;

    logic                    w_accept;
    logic                    w_resp_hs;
    logic                    w_protect;
    logic                    w_mem_we;
    logic [DATA_W-1:0]       w_mem_rdata;

    mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem_array (
        .clk     (clk),
        .rst_n   (reset),
        .wr_en   (w_mem_we),
        .wr_addr (addr_q),
        .wr_data (wdata_q),
        .rd_addr (addr_q),
        .rd_data (w_mem_rdata)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        w_mem_we     = 1'b0;

        w_accept  = req_ready_q && req_valid;
        w_resp_hs = resp_valid_q && resp_ready;
        w_protect = c_err_en && we_q && (addr_q >= ADDR_W'(RO_BASE));

        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                        cnt_d   = c_wait_load;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ACCESS;
                end else begin
                    cnt_d = cnt_q - WAIT_CNT_W'(1);
                end
            end
            ACCESS: begin
                state_d      = RESP;
                w_mem_we     = we_q && !w_protect;
                resp_rdata_d = (we_q && !w_protect) ? wdata_q : w_mem_rdata;
                resp_err_d   = w_protect;
            end
            RESP: begin
                if (w_resp_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered: valid follows RESP by one edge and drops on the handshake edge.
        req_ready_d  = (state_d == IDLE);
        resp_valid_d = (state_q == RESP) && !w_resp_hs;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_responder                                                     |
// | Two responders (2 and 0 wait states) driven from a vector table.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mem_responder;

    localparam int NDUT = 2;
    localparam int WS0  = 2;
    localparam int WS1  = 0;
    localparam int NVEC = 14;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    typedef struct {
        int         dut;
        logic       we;
        logic [4:0] addr;
        logic [7:0] wdata;
        logic       early_rr;
        logic [7:0] exp_rdata;
        logic       exp_err;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       rv [NDUT];
    logic       we [NDUT];
    logic [4:0] ad [NDUT];
    logic [7:0] wd [NDUT];
    logic       rr [NDUT];
    logic       qr [NDUT];
    logic       pv [NDUT];
    logic [7:0] pd [NDUT];
    logic       pe [NDUT];

    exp_t sb_q [$];
    vec_t vecs [NVEC];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mem_responder #(.DATA_W(8), .ADDR_W(5), .WAIT_STATES(WS0), .RO_BASE(24)) u_dut0 (
        .clk(clk), .reset(reset), .req_valid(rv[0]), .req_ready(qr[0]), .req_we(we[0]),
        .req_addr(ad[0]), .req_wdata(wd[0]), .resp_valid(pv[0]), .resp_ready(rr[0]),
        .resp_rdata(pd[0]), .resp_err(pe[0])
    );

    mem_responder #(.DATA_W(8), .ADDR_W(5), .WAIT_STATES(WS1), .RO_BASE(24)) u_dut1 (
        .clk(clk), .reset(reset), .req_valid(rv[1]), .req_ready(qr[1]), .req_we(we[1]),
        .req_addr(ad[1]), .req_wdata(wd[1]), .resp_valid(pv[1]), .resp_ready(rr[1]),
        .resp_rdata(pd[1]), .resp_err(pe[1])
    );

    function automatic int ws_of(input int k);
        return (k == 0) ? WS0 : WS1;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic run_txn(input int k, input logic w, input logic [4:0] a, input logic [7:0] d,
                           input logic early, input logic [7:0] er, input logic ee);
        int   n;
        bit   seen;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (qr[k] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_idle", {31'd0, qr[k]}, 32'd1);
        rv[k] = 1'b1; we[k] = w; ad[k] = a; wd[k] = d; rr[k] = early;
        sb_q.push_back('{rdata: er, err: ee});
        @(posedge clk);
        #1;
        rv[k] = 1'b0; we[k] = 1'($urandom); ad[k] = 5'($urandom); wd[k] = 8'($urandom);
        n = 0;
        seen = 1'b0;
        while (n < 40 && !seen) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) check("req_ready_busy", {31'd0, qr[k]}, 32'd0);
            if (pv[k] === 1'b1) seen = 1'b1;
        end
        check("latency", n, ws_of(k) + 2);
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            if (seen) begin
                check("resp_rdata", {24'd0, pd[k]}, {24'd0, e.rdata});
                check("resp_err", {31'd0, pe[k]}, {31'd0, e.err});
            end
        end
        @(negedge clk);
        rr[k] = 1'b1;
        @(posedge clk);
        #1;
        check("valid_drop", {31'd0, pv[k]}, 32'd0);
        rr[k] = 1'b0;
    endtask

    task automatic watch_no_resp(input int k, input int cycles, input string nm);
        int hits;
        hits = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (pv[k] === 1'b1) hits++;
        end
        check(nm, hits, 0);
    endtask

    initial begin
        int n;
        reset = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            rv[k] = 1'b0; we[k] = 1'b0; ad[k] = '0; wd[k] = '0; rr[k] = 1'b0;
        end

        vecs[0]  = '{0, 1'b0, 5'd5,  8'h00, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{0, 1'b1, 5'd3,  8'hA5, 1'b0, 8'hA5, 1'b0};
        vecs[2]  = '{0, 1'b0, 5'd3,  8'h00, 1'b1, 8'hA5, 1'b0};
        vecs[3]  = '{0, 1'b1, 5'd17, 8'h5A, 1'b0, 8'h5A, 1'b0};
        vecs[4]  = '{0, 1'b0, 5'd17, 8'h00, 1'b0, 8'h5A, 1'b0};
        vecs[6]  = '{1, 1'b1, 5'd0,  8'h7E, 1'b0, 8'h7E, 1'b0};
        vecs[8]  = '{1, 1'b0, 5'd0,  8'h00, 1'b1, 8'h7E, 1'b0};
        vecs[11] = '{0, 1'b1, 5'd23, 8'h11, 1'b0, 8'h11, 1'b0};
        vecs[12] = '{0, 1'b0, 5'd23, 8'h00, 1'b0, 8'h11, 1'b0};
        vecs[13] = '{1, 1'b0, 5'd3,  8'h00, 1'b0, 8'h00, 1'b0};
`ifdef MEM_RESP_ERR_EN
        vecs[5]  = '{1, 1'b1, 5'd31, 8'hC3, 1'b0, 8'h00, 1'b1};
        vecs[7]  = '{1, 1'b0, 5'd31, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[9]  = '{0, 1'b1, 5'd24, 8'hFF, 1'b0, 8'h00, 1'b1};
        vecs[10] = '{0, 1'b0, 5'd24, 8'h00, 1'b0, 8'h00, 1'b0};
`else
        vecs[5]  = '{1, 1'b1, 5'd31, 8'hC3, 1'b0, 8'hC3, 1'b0};
        vecs[7]  = '{1, 1'b0, 5'd31, 8'h00, 1'b0, 8'hC3, 1'b0};
        vecs[9]  = '{0, 1'b1, 5'd24, 8'hFF, 1'b0, 8'hFF, 1'b0};
        vecs[10] = '{0, 1'b0, 5'd24, 8'h00, 1'b0, 8'hFF, 1'b0};
`endif

        // Reset held, then released.
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check("rst_req_ready", {31'd0, qr[k]}, 32'd0);
            check("rst_resp_valid", {31'd0, pv[k]}, 32'd0);
            check("rst_resp_rdata", {24'd0, pd[k]}, 32'd0);
            check("rst_resp_err", {31'd0, pe[k]}, 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) check("rel_req_ready", {31'd0, qr[k]}, 32'd1);

        for (int i = 0; i < NVEC; i++) begin
            run_txn(vecs[i].dut, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                    vecs[i].early_rr, vecs[i].exp_rdata, vecs[i].exp_err);
        end

        // Stalled response with an ignored request pulse.
        @(negedge clk);
        check("stall_ready", {31'd0, qr[0]}, 32'd1);
        rv[0] = 1'b1; we[0] = 1'b1; ad[0] = 5'd9; wd[0] = 8'h66;
        @(posedge clk);
        #1;
        rv[0] = 1'b0;
        n = 0;
        while (n < 40 && pv[0] !== 1'b1) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("stall_latency", n, WS0 + 2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rv[0] = (i == 2); we[0] = 1'b1; ad[0] = 5'd12; wd[0] = 8'h99;
            @(posedge clk);
            #1;
            check("stall_valid", {31'd0, pv[0]}, 32'd1);
            check("stall_rdata", {24'd0, pd[0]}, 32'h66);
            check("stall_ready_low", {31'd0, qr[0]}, 32'd0);
        end
        @(negedge clk);
        rv[0] = 1'b0;
        rr[0] = 1'b1;
        @(posedge clk);
        #1;
        check("stall_valid_drop", {31'd0, pv[0]}, 32'd0);
        rr[0] = 1'b0;
        watch_no_resp(0, 10, "stall_no_extra_resp");
        run_txn(0, 1'b0, 5'd12, 8'h00, 1'b0, 8'h00, 1'b0);
        run_txn(0, 1'b0, 5'd9,  8'h00, 1'b0, 8'h66, 1'b0);

        // Reset asserted while the write to addr 7 sits in WAIT.
        @(negedge clk);
        rv[0] = 1'b1; we[0] = 1'b1; ad[0] = 5'd7; wd[0] = 8'h3C;
        @(posedge clk);
        #1;
        rv[0] = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_req_ready", {31'd0, qr[0]}, 32'd0);
        check("midrst_resp_valid", {31'd0, pv[0]}, 32'd0);
        check("midrst_resp_rdata", {24'd0, pd[0]}, 32'd0);
        check("midrst_resp_err", {31'd0, pe[0]}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        watch_no_resp(0, 10, "midrst_no_stale_resp");
        run_txn(0, 1'b0, 5'd7, 8'h00, 1'b0, 8'h00, 1'b0);
        run_txn(1, 1'b0, 5'd0, 8'h00, 1'b0, 8'h00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
